// File: rtl/ram_responder.sv
// Behavioural word RAM for the RAM end of cpu_ram_if: FREE/BUSY/ACCESS/ERROR handshake
// with an elaboration-time access latency, so controller stalls can be exercised.
module ram_responder #(
  parameter int ADDR_W = 14,
  parameter int LAT    = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] memaddr,
  input  logic [31:0] memstore,
  input  logic        memREN,
  input  logic        memWEN,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate
);

  // ramstate_t encoding from cpu_types_pkg
  localparam logic [1:0]  FREE     = 2'd0;
  localparam logic [1:0]  BUSY     = 2'd1;
  localparam logic [1:0]  ACCESS   = 2'd2;
  localparam logic [1:0]  ERROR    = 2'd3;
  localparam logic [31:0] ERR_WORD = 32'hBAD1_BAD1;
  localparam logic [3:0]  CNT_INIT = 4'(LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACC, S_ERR} state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [31:0]       r_addr_q;
  logic [31:0]       r_store_q;
  logic              r_ren_q;
  logic              r_wen_q;
  logic [31:0]       r_ramload;
  logic [1:0]        r_ramstate;
  logic [31:0]       r_mem [2**ADDR_W];

  logic              w_req;
  logic              w_illegal;
  logic              w_same;
  logic [ADDR_W-1:0] w_idx_q;
  logic [31:0]       w_acc_data;

  assign w_req      = memREN | memWEN;
  assign w_illegal  = (memREN & memWEN) | (memaddr[1:0] != 2'b00) |
                      ((memaddr >> (ADDR_W + 2)) != 32'd0);
  assign w_same     = (memaddr == r_addr_q) && (memstore == r_store_q) &&
                      (memREN == r_ren_q) && (memWEN == r_wen_q);
  assign w_idx_q    = r_addr_q[ADDR_W+1:2];
  assign w_acc_data = r_ren_q ? r_mem[w_idx_q] : r_store_q;

  // IDLE, ACC and ERR react to a new request identically; only WAIT tracks the latched one.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr_q   <= '0;
      r_store_q  <= '0;
      r_ren_q    <= 1'b0;
      r_wen_q    <= 1'b0;
      r_ramstate <= FREE;
      r_ramload  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_ACC, S_ERR: begin
          if (!w_req) begin
            r_state    <= S_IDLE;
            r_ramstate <= FREE;
            r_ramload  <= '0;
          end else if (w_illegal) begin
            r_state    <= S_ERR;
            r_ramstate <= ERROR;
            r_ramload  <= ERR_WORD;
          end else begin
            r_state    <= S_WAIT;
            r_cnt      <= CNT_INIT;
            r_addr_q   <= memaddr;
            r_store_q  <= memstore;
            r_ren_q    <= memREN;
            r_wen_q    <= memWEN;
            r_ramstate <= BUSY;
            r_ramload  <= '0;
          end
        end
        S_WAIT: begin
          if (!w_req) begin
            r_state    <= S_IDLE;
            r_ramstate <= FREE;
            r_ramload  <= '0;
          end else if (w_illegal) begin
            r_state    <= S_ERR;
            r_ramstate <= ERROR;
            r_ramload  <= ERR_WORD;
          end else if (!w_same) begin
            // Requester changed something mid-wait: restart so address and data never mix.
            r_cnt      <= CNT_INIT;
            r_addr_q   <= memaddr;
            r_store_q  <= memstore;
            r_ren_q    <= memREN;
            r_wen_q    <= memWEN;
            r_ramstate <= BUSY;
            r_ramload  <= '0;
          end else if (r_cnt == 4'd0) begin
            r_state    <= S_ACC;
            r_ramstate <= ACCESS;
            r_ramload  <= w_acc_data;
          end else begin
            r_cnt      <= r_cnt - 4'd1;
          end
        end
      endcase
    end
  end

  // Writes commit on the edge leaving ACC, and never when that edge is a reset edge.
  always_ff @(posedge CLK) begin
    if (!RST && (r_state == S_ACC) && r_wen_q) begin
      r_mem[w_idx_q] <= r_store_q;
    end
  end

  assign ramload  = r_ramload;
  assign ramstate = r_ramstate;

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: directed vector table (LAT=2), back-to-back LAT=1 reads, and
// randomized traffic checked on both instances against a cycle-level reference model.
module tb_ram_responder;

  localparam int ADDR_W = 14;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;
  localparam logic [31:0] BAD = 32'hBAD1_BAD1;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] memaddr, memstore;
  logic        memREN, memWEN;
  logic [31:0] ramload2, ramload1;
  logic [1:0]  ramstate2, ramstate1;

  always #5 CLK = ~CLK;

  ram_responder #(.ADDR_W(ADDR_W), .LAT(2)) u_dut2 (
    .CLK(CLK), .RST(RST), .memaddr(memaddr), .memstore(memstore),
    .memREN(memREN), .memWEN(memWEN), .ramload(ramload2), .ramstate(ramstate2));

  ram_responder #(.ADDR_W(ADDR_W), .LAT(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .memaddr(memaddr), .memstore(memstore),
    .memREN(memREN), .memWEN(memWEN), .ramload(ramload1), .ramstate(ramstate1));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h, required %08h", name, act, exp);
    end
  endtask

  // Reference model: index 0 is the LAT=2 instance, index 1 the LAT=1 instance.
  int          lat_of [2] = '{2, 1};
  logic [1:0]  m_kind [2];
  int          m_age  [2];
  logic [31:0] m_addr [2], m_store [2];
  logic        m_ren  [2], m_wen [2];
  logic [31:0] m_mem  [int];
  logic [1:0]  e_state [2];
  logic [31:0] e_load  [2];
  bit          e_known [2];

  function automatic int mkey(input int d, input logic [31:0] a);
    return d * (1 << 20) + int'(a[ADDR_W+1:2]);
  endfunction

  task automatic model_step(input int d);
    bit req, bad, same;
    req = memREN | memWEN;
    bad = (memREN && memWEN) || (memaddr[1:0] != 2'b00) || (memaddr >= 32'(4 << ADDR_W));
    if (m_kind[d] == ACCESS && m_wen[d] && !RST) m_mem[mkey(d, m_addr[d])] = m_store[d];
    e_known[d] = 1'b1;
    e_load[d]  = 32'd0;
    if (RST) begin
      m_kind[d] = FREE;  m_age[d] = 0;
      m_addr[d] = 0;  m_store[d] = 0;  m_ren[d] = 0;  m_wen[d] = 0;
    end else if (!req) begin
      m_kind[d] = FREE;
    end else if (bad) begin
      m_kind[d] = ERROR;
      e_load[d] = BAD;
    end else begin
      same = (m_kind[d] == BUSY) && memaddr == m_addr[d] && memstore == m_store[d] &&
             memREN == m_ren[d] && memWEN == m_wen[d];
      if (same) m_age[d]++;
      else begin
        m_age[d] = 1;
        m_addr[d] = memaddr;  m_store[d] = memstore;  m_ren[d] = memREN;  m_wen[d] = memWEN;
      end
      if (m_age[d] > lat_of[d]) begin
        m_kind[d] = ACCESS;
        if (!m_ren[d]) e_load[d] = m_store[d];
        else if (m_mem.exists(mkey(d, m_addr[d]))) e_load[d] = m_mem[mkey(d, m_addr[d])];
        else e_known[d] = 1'b0;
      end else begin
        m_kind[d] = BUSY;
      end
    end
    e_state[d] = m_kind[d];
  endtask

  task automatic step(input bit rst, input bit ren, input bit wen,
                      input logic [31:0] addr, input logic [31:0] store);
    RST = rst;  memREN = ren;  memWEN = wen;  memaddr = addr;  memstore = store;
    @(posedge CLK);
    model_step(0);
    model_step(1);
    #1;
    check("model_lat2_state", ramstate2, e_state[0]);
    if (e_known[0]) check("model_lat2_load", ramload2, e_load[0]);
    check("model_lat1_state", ramstate1, e_state[1]);
    if (e_known[1]) check("model_lat1_load", ramload1, e_load[1]);
  endtask

  typedef struct {
    bit          rst, ren, wen;
    logic [31:0] addr, store;
    logic [1:0]  est;
    logic [31:0] eld;
    string       name;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit rst, input bit ren, input bit wen, input logic [31:0] addr,
                     input logic [31:0] store, input logic [1:0] est, input logic [31:0] eld,
                     input string name);
    vec_t v;
    v.rst = rst;  v.ren = ren;  v.wen = wen;  v.addr = addr;  v.store = store;
    v.est = est;  v.eld = eld;  v.name = name;
    tbl.push_back(v);
  endtask

  task automatic add_idle(input string name);
    add(0, 0, 0, 32'h0, 32'h0, FREE, 32'h0, name);
  endtask

  bit          r_ren, r_wen, r_rst;
  logic [31:0] r_addr, r_store;
  int          hold;

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_kind[i] = FREE;  m_age[i] = 0;  m_addr[i] = 0;  m_store[i] = 0;
      m_ren[i] = 0;  m_wen[i] = 0;
    end
    RST = 1'b1;  memREN = 0;  memWEN = 0;  memaddr = 0;  memstore = 0;

    // Directed vectors for the LAT=2 instance: outputs expected right after each edge.
    add(1, 0, 0, 32'h0, 32'h0, FREE, 32'h0, "reset");
    for (int i = 0; i < 5; i++) add_idle("idle_free");
    for (int i = 0; i < 2; i++) add(0, 0, 1, 32'h100, 32'hDEADBEEF, BUSY, 32'h0, "wr100_busy");
    add(0, 0, 1, 32'h100, 32'hDEADBEEF, ACCESS, 32'hDEADBEEF, "wr100_access");
    for (int i = 0; i < 2; i++) add(0, 1, 0, 32'h100, 32'h0, BUSY, 32'h0, "rd100_busy");
    add(0, 1, 0, 32'h100, 32'h0, ACCESS, 32'hDEADBEEF, "rd100_access");
    add_idle("after_rd_free");
    for (int i = 0; i < 2; i++) add(0, 0, 1, 32'h104, 32'h12345678, BUSY, 32'h0, "wr104_busy");
    add(0, 0, 1, 32'h104, 32'h12345678, ACCESS, 32'h12345678, "wr104_access");
    add_idle("after_wr_free");
    add(0, 1, 0, 32'h100, 32'h0, BUSY, 32'h0, "chg_first_busy");
    add(0, 1, 0, 32'h104, 32'h0, BUSY, 32'h0, "chg_restart_busy");
    add(0, 1, 0, 32'h104, 32'h0, BUSY, 32'h0, "chg_busy2");
    add(0, 1, 0, 32'h104, 32'h0, ACCESS, 32'h12345678, "chg_access_104");
    add_idle("chg_free");
    for (int i = 0; i < 2; i++) add(0, 1, 0, 32'h100, 32'h0, BUSY, 32'h0, "rd100b_busy");
    add(0, 1, 0, 32'h100, 32'h0, ACCESS, 32'hDEADBEEF, "rd100_untouched");
    add_idle("free");
    add(0, 1, 1, 32'h100, 32'h0, ERROR, BAD, "both_err");
    add(0, 1, 1, 32'h100, 32'h0, ERROR, BAD, "both_err_held");
    add_idle("both_err_drop_free");
    add(0, 1, 0, 32'h102, 32'h0, ERROR, BAD, "misalign_err");
    add_idle("misalign_drop_free");
    add(0, 1, 0, 32'h10000, 32'h0, ERROR, BAD, "range_err");
    add_idle("range_drop_free");
    for (int i = 0; i < 2; i++) add(0, 0, 1, 32'hFFFC, 32'hA5A5F00F, BUSY, 32'h0, "wr_top_busy");
    add(0, 0, 1, 32'hFFFC, 32'hA5A5F00F, ACCESS, 32'hA5A5F00F, "wr_top_access");
    add_idle("free");
    add(0, 1, 0, 32'h102, 32'h0, ERROR, BAD, "err_again");
    for (int i = 0; i < 2; i++) add(0, 1, 0, 32'hFFFC, 32'h0, BUSY, 32'h0, "err_to_busy");
    add(0, 1, 0, 32'hFFFC, 32'h0, ACCESS, 32'hA5A5F00F, "rd_top_access");
    add_idle("free");
    for (int i = 0; i < 2; i++) add(0, 0, 1, 32'h200, 32'h11112222, BUSY, 32'h0, "pre200_busy");
    add(0, 0, 1, 32'h200, 32'h11112222, ACCESS, 32'h11112222, "pre200_access");
    add_idle("free");
    for (int i = 0; i < 2; i++) add(0, 0, 1, 32'h200, 32'h33334444, BUSY, 32'h0, "abort_busy");
    add(0, 0, 1, 32'h200, 32'h33334444, ACCESS, 32'h33334444, "abort_access");
    add(1, 0, 1, 32'h200, 32'h33334444, FREE, 32'h0, "abort_reset");
    add_idle("free");
    for (int i = 0; i < 2; i++) add(0, 1, 0, 32'h200, 32'h0, BUSY, 32'h0, "rd200_busy");
    add(0, 1, 0, 32'h200, 32'h0, ACCESS, 32'h11112222, "rd200_kept_preload");
    add_idle("free");

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].ren, tbl[i].wen, tbl[i].addr, tbl[i].store);
      check({tbl[i].name, "_state"}, ramstate2, tbl[i].est);
      check({tbl[i].name, "_load"}, ramload2, tbl[i].eld);
    end

    // LAT=1: fill words 0x0..0xC, then read them back-to-back with no FREE gaps.
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 3; k++) step(0, 0, 1, 32'(4 * i), 32'hC0DE_0000 | 32'(i));
      step(0, 0, 0, 32'h0, 32'h0);
    end
    step(0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 32'(4 * i), 32'h0);
      check("b2b_lat1_busy", ramstate1, BUSY);
      step(0, 1, 0, 32'(4 * i), 32'h0);
      check("b2b_lat1_access", ramstate1, ACCESS);
      check("b2b_lat1_data", ramload1, 32'hC0DE_0000 | 32'(i));
    end
    step(0, 0, 0, 32'h0, 32'h0);
    check("b2b_lat1_end_free", ramstate1, FREE);

    // Randomized traffic: held requests, mid-request changes, illegal accesses, rare resets.
    hold = 0;
    r_ren = 0;  r_wen = 0;  r_addr = 0;  r_store = 0;
    for (int n = 0; n < 800; n++) begin
      if (hold == 0) begin
        int k;
        hold = $urandom_range(1, 6);
        k = $urandom_range(0, 15);
        r_ren = (k >= 3 && k < 8) || k == 15;
        r_wen = k >= 8;
        r_addr = 32'(4 * $urandom_range(0, 15));
        if ($urandom_range(0, 15) == 0) r_addr = r_addr + 32'd2;
        if ($urandom_range(0, 31) == 0) r_addr = r_addr + 32'h10000;
        r_store = $urandom;
      end
      hold--;
      r_rst = ($urandom_range(0, 63) == 0);
      step(r_rst, r_ren, r_wen, r_addr, r_store);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
# ram_responder

Behavioural RAM that sits on the RAM end of `cpu_ram_if`, opposite `memory_control`. It accepts word reads and writes driven by the memory controller (`memaddr`, `memstore`, `memREN`, `memWEN`) and returns `ramload` plus a `ramstate_t` handshake (FREE/BUSY/ACCESS/ERROR) with a parameterised access latency. It replaces the external RAM model in single-cycle and pipeline system benches, so controller stalls can be exercised at any latency.

## Interface
- `ADDR_W`, 14: word-address width; the array holds 2^ADDR_W 32-bit words, so byte addresses 0 .. 4·2^ADDR_W−1 are legal.
- `LAT`, 2: BUSY cycles before ACCESS; legal range 1..15.
- `CLK`  in  1: clock; all state updates on the rising edge.
- `RST`  in  1: reset, synchronous, active-high.
- `memaddr`  in  32: byte address (`word_t`).
- `memstore`  in  32: write data.
- `memREN`  in  1: read request.
- `memWEN`  in  1: write request.
- `ramload`  out  32: read data; valid only while `ramstate` == ACCESS.
- `ramstate`  out  2: `ramstate_t` from `cpu_types_pkg`: FREE, BUSY, ACCESS or ERROR.

## Operation
- Request present (`req`) = `memREN | memWEN`.
- Illegal request:
  - `memREN & memWEN`, or
  - `memaddr[1:0]` != 0, or
  - `memaddr[31:ADDR_W+2]` != 0.
- FSM states: IDLE, WAIT, ACC, ERR. Outputs are Moore, taken from the registered state.
  - IDLE: `ramstate`=FREE, `ramload`=0.
  - WAIT: `ramstate`=BUSY, `ramload`=0.
  - ACC: `ramstate`=ACCESS, `ramload`=`mem[addr_q]` for reads, `memstore` echo for writes.
  - ERR: `ramstate`=ERROR, `ramload`=32'hBAD1BAD1.
- IDLE:
  - no `req`: stay in IDLE.
  - legal `req`: latch {addr, REN, WEN, store} into `_q`, `cnt`←LAT−1, go to WAIT.
  - illegal `req`: go to ERR.
- WAIT:
  - Live inputs are compared with the `_q` latches every cycle.
  - Any mismatch: relatch, reload `cnt`←LAT−1, stay in WAIT (restart).
  - `req` dropped: go to IDLE, no array side effect.
  - Inputs become illegal: go to ERR.
  - Otherwise: `cnt`==0 → ACC, else `cnt`−1.
- ACC (exactly one cycle):
  - A write commits `mem[addr_q[ADDR_W+1:2]]`←`store_q` on the edge leaving ACC. A read has no side effect.
  - Next state: legal `req` → relatch and go to WAIT with `cnt`←LAT−1 (back-to-back). Illegal `req` → ERR. No `req` → IDLE.
- ERR: held while inputs remain illegal. Legal `req` → latch and go to WAIT. No `req` → IDLE.
- The array is not cleared by reset. Contents are undefined until written; benches preload through `$readmemh` on a hierarchical path.

## Timing
- Reset: state=IDLE, `cnt`=0, latches=0. Outputs the cycle after the reset edge: `ramstate`=FREE, `ramload`=0.
- Reset during WAIT or ACC: any pending write is dropped. A write is not committed if `RST` is high on the edge that would have left ACC.
- Legal request first sampled at edge e: BUSY for cycles e+1 .. e+LAT, ACCESS at cycle e+LAT+1. Request-to-ACCESS latency is LAT+1 cycles.
- Requester rule: hold all request inputs stable from assertion through the ACCESS cycle.
- Dropping or changing a request before ACCESS: the access is aborted or restarted. It never completes with mixed address and data.
- Back-to-back requests: ACCESS, then BUSY×LAT, then ACCESS. There is no FREE gap if `req` stays high.
- Read-after-write to the same address: the write commits at the end of its ACCESS cycle, so the following read returns the new data.
- LAT is fixed at elaboration. A `cnt` width of 4 bits is sufficient.

## Test plan
- Reset, then IDLE with no `req` → `ramstate`=FREE and `ramload`=0 for 5 cycles.
- LAT=2: write 0xDEADBEEF to 0x100, then read 0x100 → each request shows BUSY, BUSY, ACCESS. The read's ACCESS shows `ramload`=0xDEADBEEF.
- LAT=2: `memaddr` changes 0x100→0x104 during the first BUSY cycle → BUSY counter restarts. ACCESS arrives 3 cycles after the change, carrying `mem[0x104]`, and `mem[0x100]` is untouched.
- Illegal requests:
  - `memREN`=`memWEN`=1 → ERROR and `ramload`=0xBAD1BAD1 while held.
  - `memaddr`=0x102 → ERROR.
  - `memaddr`=4·2^ADDR_W → ERROR.
  - After each, deasserting the request → FREE the next cycle.
- Write to 0x200 with `RST` pulsed in its ACCESS cycle, then a later read of 0x200 → the read returns the preloaded value, not the aborted write data.
- LAT=1, 4 consecutive reads 0x0..0xC held back-to-back → repeating BUSY, ACCESS pattern with no FREE cycles, and the correct word in each ACCESS.
